instruction_compressor: RTL and testbench
=========================================

Name: instruction_compressor

Overview:
- Hardware token-dictionary compressor for 32-bit instruction streams; the encoding end of the compressed-instruction format the decompressor consumes.
- Matches each incoming instruction against a loadable token table and emits a TOKEN_BITS code on a hit. On a miss it emits the escape code followed by the raw instruction.
- Packs the variable-length codes LSB-first into 32-bit words for the compressed-image memory.

Parameters:
- WIDTH, 32, instruction and output word width.
- TOKEN_BITS, 4, code width; table holds 2**TOKEN_BITS-1 entries.
- ESCAPE, 4'b1111, reserved code that prefixes a raw instruction; never a table index.
- CNT_W, 16, width of statistics counters.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- tbl_we  in  1  table write strobe.
- tbl_addr  in  TOKEN_BITS  table entry index.
- tbl_data  in  WIDTH  instruction stored at tbl_addr.
- in_valid  in  1  instruction present.
- in_ready  out  1  instruction accepted when in_valid&in_ready.
- in_instr  in  WIDTH  instruction to compress.
- in_last  in  1  marks final instruction of the stream.
- out_valid  out  1  packed word available.
- out_ready  in  1  consumer accepts word when out_valid&out_ready.
- out_word  out  WIDTH  packed compressed word.
- out_last  out  1  final word of the stream (qualified by out_valid).
- match_count  out  CNT_W  instructions encoded as tokens since reset, saturating.
- raw_count  out  CNT_W  instructions encoded raw since reset, saturating.

Behaviour:
- Reset (async): accumulator and fill cleared, all table valid bits cleared, state=RUN, out_valid=0, out_last=0, in_ready=1 after release, counters=0.
- Table writes:
  - A write sets entry data and valid bit.
  - A write with tbl_addr==ESCAPE is ignored.
  - A write takes effect for instructions accepted in the following cycle onward.
  - Unwritten entries never match.
- Match: combinational compare against all valid entries. On a hit, the lowest matching index wins.
  - Hit appends a TOKEN_BITS-bit code (n=4).
  - Miss appends ESCAPE in the low bits, then in_instr (n=36).
- Accumulator: 64 bits, fill 0..64, bits appended at position fill (LSB-first).
- in_ready=1 iff state==RUN and fill<=28.
- Latency: accepted bits are visible in the accumulator the next cycle.
- out_valid=1 when fill>=32, or in FLUSH with fill>0. out_word=acc[31:0].
  - On output handshake: acc shifts right 32, fill drops by 32 (floor 0).
- Simultaneous accept and emit in the same cycle: fill_next = fill + n - 32. No loss, no overflow.
- States:
  - RUN: accepting an instruction with in_last=1 moves to FLUSH.
  - FLUSH: in_ready=0. Remaining words are drained. The final word, with fill<=32, is zero-padded above fill and carries out_last=1. Its handshake returns to RUN with fill=0.
  - The table persists across streams.
- Output stability: out_word and out_last hold while out_valid=1 and out_ready=0.
- Counters: match_count increments on accepted hits, raw_count on accepted misses. Both saturate at all-ones.
- Reset mid-stream: all in-flight bits are discarded, no out_last is emitted, and the table is invalidated.

Decomposition:
- Package compressor_pkg holds:
  - WIDTH, TOKEN_BITS, ESCAPE, ACC_W=64;
  - state enum {RUN, FLUSH};
  - code-length constants TOKEN_LEN=4, RAW_LEN=36.
- One sub-module, token_matcher: table registers with valid bits, write port, parallel compare, priority encoder. Outputs hit and index.
- The packer and FSM stay in the top module.

Test Plan:
- table[3]=E1A00000; stream 8x E1A00000, last on 8th -> single word 0x33333333 with out_last=1; match_count=8, raw_count=0.
- Empty table; stream DEADBEEF with last -> word0=0xEADBEEFF, then word1=0x0000000D with out_last=1; raw_count=1.
- table[1]=E12FFF1E; stream E12FFF1E, DEADBEEF, E12FFF1E(last) -> 0xADBEEFF1, then 0x000001DE with out_last=1.
- out_ready=0; stream raw instructions -> in_ready falls after first accept (fill=36); raising out_ready drains 0xEADBEEFF-style words with no dropped or duplicated bits; in_ready re-asserts when fill<=28.
- table[2]=table[5]=E1A00000 and a write to addr F -> hit encodes as code 2; entry F never matches.
- Assert reset during FLUSH with out_valid=1 -> out_valid=0 immediately; after release, streaming E1A00000 emits ESCAPE+raw (table cleared).

Source files
------------

// File: rtl/compressor_pkg.sv
// Shared constants and types for the token-dictionary instruction compressor.
// Code lengths, accumulator geometry and the packer state encoding live here.
package compressor_pkg;

  localparam int WIDTH       = 32;
  localparam int TOKEN_BITS  = 4;
  localparam int NUM_ENTRIES = (2 ** TOKEN_BITS) - 1;
  localparam logic [TOKEN_BITS-1:0] ESCAPE = 4'b1111;
  localparam int CNT_W       = 16;
  localparam int ACC_W       = 64;
  localparam int FILL_W      = 7;
  localparam int TOKEN_LEN   = TOKEN_BITS;
  localparam int RAW_LEN     = TOKEN_BITS + WIDTH;
  // Highest fill that still leaves room for a worst-case (raw) append.
  localparam int ACCEPT_MAX  = ACC_W - RAW_LEN;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/token_matcher.sv
// Loadable token table with per-entry valid bits and a parallel compare.
// The lowest-numbered valid entry equal to the instruction is reported.
module token_matcher
  import compressor_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_we,
  input  logic [TOKEN_BITS-1:0] i_addr,
  input  logic [WIDTH-1:0]      i_data,
  input  logic [WIDTH-1:0]      i_instr,
  output logic                  o_hit,
  output logic [TOKEN_BITS-1:0] o_index
);

  logic [NUM_ENTRIES-1:0] w_eq;

  // Entry indices stop below ESCAPE, so a write to that address selects nothing.
  generate
    for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
      logic [WIDTH-1:0] r_data;
      logic             r_valid;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_data  <= '0;
          r_valid <= 1'b0;
        end else if (i_we && (i_addr == TOKEN_BITS'(gi))) begin
          r_data  <= i_data;
          r_valid <= 1'b1;
        end
      end

      assign w_eq[gi] = r_valid && (r_data == i_instr);
    end
  endgenerate

  always_comb begin
    o_hit   = |w_eq;
    o_index = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (w_eq[i]) o_index = TOKEN_BITS'(i);
    end
  end

endmodule

// File: rtl/instruction_compressor.sv
// Encodes instructions as table tokens or ESCAPE+raw and packs the
// variable-length codes LSB-first into 32-bit words.
module instruction_compressor
  import compressor_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tbl_we,
  input  logic [TOKEN_BITS-1:0] tbl_addr,
  input  logic [WIDTH-1:0]      tbl_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_instr,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_word,
  output logic                  out_last,
  output logic [CNT_W-1:0]      match_count,
  output logic [CNT_W-1:0]      raw_count
);

  localparam logic [FILL_W-1:0] L_WORD    = FILL_W'(WIDTH);
  localparam logic [FILL_W-1:0] L_ACC_MAX = FILL_W'(ACCEPT_MAX);
  localparam logic [FILL_W-1:0] L_TOKEN   = FILL_W'(TOKEN_LEN);
  localparam logic [FILL_W-1:0] L_RAW     = FILL_W'(RAW_LEN);

  state_t             r_state;
  logic [ACC_W-1:0]   r_acc;
  logic [FILL_W-1:0]  r_fill;
  logic [CNT_W-1:0]   r_match_cnt;
  logic [CNT_W-1:0]   r_raw_cnt;

  logic                  w_hit;
  logic [TOKEN_BITS-1:0] w_index;
  logic                  w_accept;
  logic                  w_emit;
  logic                  w_final;
  logic [RAW_LEN-1:0]    w_code;
  logic [FILL_W-1:0]     w_len;
  logic [ACC_W-1:0]      w_acc_sh;
  logic [FILL_W-1:0]     w_fill_sh;
  logic [ACC_W-1:0]      w_acc_next;
  logic [FILL_W-1:0]     w_fill_next;

  token_matcher u_matcher (
    .clk     (clk),
    .reset   (reset),
    .i_we    (tbl_we),
    .i_addr  (tbl_addr),
    .i_data  (tbl_data),
    .i_instr (in_instr),
    .o_hit   (w_hit),
    .o_index (w_index)
  );

  assign in_ready    = (r_state == RUN) && (r_fill <= L_ACC_MAX);
  assign out_valid   = (r_fill >= L_WORD) || ((r_state == FLUSH) && (r_fill != '0));
  assign out_word    = r_acc[WIDTH-1:0];
  assign out_last    = (r_state == FLUSH) && (r_fill != '0) && (r_fill <= L_WORD);
  assign match_count = r_match_cnt;
  assign raw_count   = r_raw_cnt;

  assign w_accept = in_valid && in_ready;
  assign w_emit   = out_valid && out_ready;
  assign w_final  = w_emit && out_last;
  assign w_code   = w_hit ? RAW_LEN'(w_index) : {in_instr, ESCAPE};
  assign w_len    = w_hit ? L_TOKEN : L_RAW;

  // Bits above fill are kept zero, so the final word is padded for free.
  always_comb begin
    w_acc_sh  = r_acc;
    w_fill_sh = r_fill;
    if (w_emit) begin
      w_acc_sh  = r_acc >> WIDTH;
      w_fill_sh = (r_fill >= L_WORD) ? (r_fill - L_WORD) : '0;
    end
    w_acc_next  = w_acc_sh;
    w_fill_next = w_fill_sh;
    if (w_accept) begin
      w_acc_next  = w_acc_sh | ({{(ACC_W-RAW_LEN){1'b0}}, w_code} << w_fill_sh);
      w_fill_next = w_fill_sh + w_len;
    end
    if (w_final) begin
      w_acc_next  = '0;
      w_fill_next = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= RUN;
      r_acc       <= '0;
      r_fill      <= '0;
      r_match_cnt <= '0;
      r_raw_cnt   <= '0;
    end else begin
      r_acc  <= w_acc_next;
      r_fill <= w_fill_next;
      case (r_state)
        RUN:     if (w_accept && in_last) r_state <= FLUSH;
        FLUSH:   if (w_final) r_state <= RUN;
        default: r_state <= RUN;
      endcase
      if (w_accept && w_hit)  r_match_cnt <= sat_inc(r_match_cnt);
      if (w_accept && !w_hit) r_raw_cnt   <= sat_inc(r_raw_cnt);
    end
  end

endmodule

// File: tb/tb_instruction_compressor.sv
// Scoreboard bench for instruction_compressor: expected words are queued when
// instructions are sent and checked as the DUT hands packed words out.
module tb_instruction_compressor;
  import compressor_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  tbl_we = 1'b0;
  logic [TOKEN_BITS-1:0] tbl_addr = '0;
  logic [WIDTH-1:0]      tbl_data = '0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [WIDTH-1:0]      in_instr = '0;
  logic                  in_last = 1'b0;
  logic                  out_valid;
  logic                  out_ready = 1'b1;
  logic [WIDTH-1:0]      out_word;
  logic                  out_last;
  logic [CNT_W-1:0]      match_count;
  logic [CNT_W-1:0]      raw_count;

  int n_cmp = 0;
  int n_bad = 0;
  bit done  = 1'b0;

  logic [32:0]  exp_q[$];
  logic [31:0]  m_tbl[16];
  logic [15:0]  m_vld = '0;
  logic [127:0] m_acc = '0;
  int           m_fill = 0;

  always #5 clk = ~clk;

  instruction_compressor dut (
    .clk         (clk),
    .reset       (reset),
    .tbl_we      (tbl_we),
    .tbl_addr    (tbl_addr),
    .tbl_data    (tbl_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_word    (out_word),
    .out_last    (out_last),
    .match_count (match_count),
    .raw_count   (raw_count)
  );

  // Output side of the scoreboard: a word handed out is popped and compared.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      logic [32:0] e;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_word got %h last=%b, none expected", out_word, out_last);
      end else begin
        e = exp_q.pop_front();
        if ({out_last, out_word} !== e) begin
          n_bad++;
          $display("FAIL word got %h last=%b, required %h last=%b", out_word, out_last, e[31:0], e[32]);
        end else begin
          $display("word %h last=%b", out_word, out_last);
        end
      end
    end
  end

  // Independent packer model used for the longer streams.
  task automatic model_push(input logic [31:0] instr, input logic last);
    logic [35:0] code;
    int n;
    int idx;
    idx = -1;
    for (int i = 14; i >= 0; i--) if (m_vld[i] && m_tbl[i] == instr) idx = i;
    if (idx >= 0) begin
      code = 36'(idx);
      n = 4;
    end else begin
      code = {instr, 4'hF};
      n = 36;
    end
    m_acc = m_acc | (128'(code) << m_fill);
    m_fill += n;
    while (m_fill > 32 || (m_fill == 32 && !last)) begin
      exp_q.push_back({1'b0, m_acc[31:0]});
      m_acc = m_acc >> 32;
      m_fill -= 32;
    end
    if (last) begin
      exp_q.push_back({1'b1, m_acc[31:0]});
      m_acc = '0;
      m_fill = 0;
    end
  endtask

  task automatic model_reset();
    m_vld = '0;
    m_acc = '0;
    m_fill = 0;
    exp_q.delete();
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    in_valid = 1'b0;
    tbl_we = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  task automatic tbl_write(input logic [3:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    tbl_we = 1'b1;
    tbl_addr = addr;
    tbl_data = data;
    @(posedge clk); #1;
    tbl_we = 1'b0;
    if (addr != 4'hF) begin
      m_tbl[addr] = data;
      m_vld[addr] = 1'b1;
    end
  endtask

  task automatic send(input logic [31:0] instr, input logic last, input bit use_model);
    int cyc;
    if (use_model) model_push(instr, last);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_instr = instr;
    in_last = last;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      cyc++;
      if (cyc > 200) begin
        n_cmp++;
        n_bad++;
        $display("FAIL send_timeout in_ready=%b required 1", in_ready);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || out_valid) && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (exp_q.size() != 0 || out_valid) begin
      n_bad++;
      $display("FAIL %s_drain pending=%0d out_valid=%b, required 0/0", name, exp_q.size(), out_valid);
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got %b required 0", out_valid); end
    apply_reset();
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready got %b required 1", in_ready); end
    n_cmp++;
    if (out_last !== 1'b0) begin n_bad++; $display("FAIL rst_out_last got %b required 0", out_last); end
    n_cmp++;
    if (match_count !== '0 || raw_count !== '0) begin
      n_bad++;
      $display("FAIL rst_counters got %0d/%0d required 0/0", match_count, raw_count);
    end
  endtask

  task automatic test_all_tokens();
    apply_reset();
    tbl_write(4'd3, 32'hE1A00000);
    exp_q.push_back({1'b1, 32'h33333333});
    for (int i = 0; i < 8; i++) send(32'hE1A00000, (i == 7), 1'b0);
    wait_drain("all_tokens");
    n_cmp++;
    if (match_count !== 16'd8 || raw_count !== 16'd0) begin
      n_bad++;
      $display("FAIL tokens_counters got %0d/%0d required 8/0", match_count, raw_count);
    end
  endtask

  task automatic test_raw();
    apply_reset();
    exp_q.push_back({1'b0, 32'hEADBEEFF});
    exp_q.push_back({1'b1, 32'h0000000D});
    send(32'hDEADBEEF, 1'b1, 1'b0);
    wait_drain("raw");
    n_cmp++;
    if (raw_count !== 16'd1 || match_count !== 16'd0) begin
      n_bad++;
      $display("FAIL raw_counters got %0d/%0d required 0/1", match_count, raw_count);
    end
  endtask

  task automatic test_mixed();
    tbl_write(4'd1, 32'hE12FFF1E);
    exp_q.push_back({1'b0, 32'hADBEEFF1});
    exp_q.push_back({1'b1, 32'h000001DE});
    send(32'hE12FFF1E, 1'b0, 1'b0);
    send(32'hDEADBEEF, 1'b0, 1'b0);
    send(32'hE12FFF1E, 1'b1, 1'b0);
    wait_drain("mixed");
    n_cmp++;
    if (match_count !== 16'd2 || raw_count !== 16'd2) begin
      n_bad++;
      $display("FAIL mixed_counters got %0d/%0d required 2/2", match_count, raw_count);
    end
  endtask

  task automatic test_backpressure();
    logic [32:0] head;
    out_ready = 1'b0;
    send(32'hDEADBEEF, 1'b0, 1'b1);
    head = exp_q[0];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL bp_stall in_ready=%b out_valid=%b, required 0/1", in_ready, out_valid);
      end
      n_cmp++;
      if (out_word !== head[31:0] || out_last !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold got %h last=%b, required %h last=0", out_word, out_last, head[31:0]);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_reready got %b required 1", in_ready); end
    send(32'h12345678, 1'b0, 1'b1);
    send(32'hCAFEF00D, 1'b0, 1'b1);
    send(32'hE12FFF1E, 1'b1, 1'b1);
    wait_drain("backpressure");
  endtask

  task automatic test_priority();
    apply_reset();
    tbl_write(4'd2, 32'hE1A00000);
    tbl_write(4'd5, 32'hE1A00000);
    tbl_write(4'hF, 32'h12345678);
    exp_q.push_back({1'b0, 32'h345678F2});
    exp_q.push_back({1'b1, 32'h00000012});
    send(32'hE1A00000, 1'b0, 1'b0);
    send(32'h12345678, 1'b1, 1'b0);
    wait_drain("priority");
    n_cmp++;
    if (match_count !== 16'd1 || raw_count !== 16'd1) begin
      n_bad++;
      $display("FAIL prio_counters got %0d/%0d required 1/1", match_count, raw_count);
    end
  endtask

  task automatic test_random();
    logic [31:0] pool[6];
    pool = '{32'hE1A00000, 32'h00000000, 32'hE3A01001, 32'h0BADF00D, 32'hE12FFF1E, 32'h7FFFFFFF};
    tbl_write(4'd0, 32'h00000000);
    tbl_write(4'd7, 32'hE3A01001);
    tbl_write(4'd14, 32'h7FFFFFFF);
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) send(pool[$urandom_range(0, 5)], (i == 59), 1'b1);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    wait_drain("random");
  endtask

  task automatic test_reset_flush();
    out_ready = 1'b0;
    send(32'hDEADBEEF, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || out_last !== 1'b0) begin
      n_bad++;
      $display("FAIL rf_pending out_valid=%b out_last=%b, required 1/0", out_valid, out_last);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_last !== 1'b0) begin
      n_bad++;
      $display("FAIL rf_async out_valid=%b out_last=%b, required 0/0", out_valid, out_last);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    out_ready = 1'b1;
    exp_q.push_back({1'b0, 32'h1A00000F});
    exp_q.push_back({1'b1, 32'h0000000E});
    send(32'hE1A00000, 1'b1, 1'b0);
    wait_drain("reset_flush");
    n_cmp++;
    if (match_count !== 16'd0 || raw_count !== 16'd1) begin
      n_bad++;
      $display("FAIL rf_counters got %0d/%0d required 0/1", match_count, raw_count);
    end
  endtask

  initial begin
    test_reset();
    test_all_tokens();
    test_raw();
    test_mixed();
    test_backpressure();
    test_priority();
    test_random();
    test_reset_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule
